// File: rtl/div_seq5x3_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package div_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DW_DEF = 5;
  localparam int unsigned VW_DEF = 3;
  localparam int unsigned CW_DEF = $clog2(DW_DEF);

endpackage

// File: rtl/div_seq5x3_step.sv
// One restoring-division iteration: shift in a dividend bit, conditionally subtract.
module div_step #(
  parameter int unsigned VW = 3
) (
  input  logic [VW:0]   pr,
  input  logic          bit_in,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   pr_next,
  output logic          q_bit
);

  logic [VW:0] shifted;
  logic [VW:0] dvs_ext;

  always_comb begin
    // pr is always below divisor on entry, so the top bit drops out of the shift
    shifted = (VW+1)'({pr, bit_in});
    dvs_ext = {1'b0, divisor};
    pr_next = shifted;
    q_bit   = 1'b0;
    if (shifted >= dvs_ext) begin
      pr_next = shifted - dvs_ext;
      q_bit   = 1'b1;
    end
  end

endmodule

// File: rtl/div_seq5x3.sv
// Sequential unsigned divider with valid/ready handshakes, one quotient bit per clock.
module div_seq5x3
  import div_seq_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          dbz
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [VW:0]   pr;
  logic [VW:0]   pr_next;
  logic [DW-1:0] sh;
  logic [VW-1:0] dvs;
  logic          q_bit;

  div_step #(.VW(VW)) u_step (
    .pr      (pr),
    .bit_in  (sh[DW-1]),
    .divisor (dvs),
    .pr_next (pr_next),
    .q_bit   (q_bit)
  );

  // sh starts as the dividend and fills with quotient bits from the LSB as it drains
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
      cnt       <= '0;
      pr        <= '0;
      sh        <= '0;
      dvs       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvs      <= divisor;
            sh       <= dividend;
            pr       <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= '0;
              dbz       <= 1'b1;
              state     <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          pr <= pr_next;
          sh <= DW'({sh, q_bit});
          if (cnt == CW'(DW - 1)) begin
            cnt       <= '0;
            quotient  <= DW'({sh, q_bit});
            remainder <= pr_next[VW-1:0];
            dbz       <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          // divide-by-zero enters DONE with out_valid low; it rises one cycle later
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq5x3.sv
// Randomized/exhaustive check of div_seq5x3 against a plain-arithmetic divider model.
module tb_div_seq5x3;

  localparam int unsigned DW = 5;
  localparam int unsigned VW = 3;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          dbz;

  int total;
  int bad;

  div_seq5x3 #(.DW(DW), .VW(VW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference result from plain integer division
  function automatic void model(input int a, input int b, output int q, output int r, output int z);
    if (b == 0) begin
      q = (1 << DW) - 1;
      r = 0;
      z = 1;
    end else begin
      q = a / b;
      r = a % b;
      z = 0;
    end
  endfunction

  // One transaction starting at a negedge in IDLE; hold = cycles of out_ready low after out_valid
  task automatic run_op(input int a, input int b, input int hold, input bit noise);
    int eq, er, ez, lat;
    model(a, b, eq, er, ez);
    check("in_ready_idle", int'(in_ready), 1);
    in_valid  = 1'b1;
    dividend  = DW'(a);
    divisor   = VW'(b);
    out_ready = noise ? 1'b1 : 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (noise) begin
        in_valid = 1'($urandom);
        dividend = DW'($urandom);
        divisor  = VW'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (!out_valid) check("in_ready_busy", int'(in_ready), 0);
    end
    out_ready = 1'b0;
    check("latency", lat, (b == 0) ? 1 : int'(DW));
    check("quotient", int'(quotient), eq);
    check("remainder", int'(remainder), er);
    check("dbz", int'(dbz), ez);
    for (int i = 0; i < hold; i++) begin
      if (noise) begin
        in_valid = 1'($urandom);
        dividend = DW'($urandom);
        divisor  = VW'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", int'(out_valid), 1);
      check("hold_in_ready", int'(in_ready), 0);
      check("hold_quotient", int'(quotient), eq);
      check("hold_remainder", int'(remainder), er);
      check("hold_dbz", int'(dbz), ez);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("consumed_valid", int'(out_valid), 0);
    check("consumed_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    int seen;
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_dbz", int'(dbz), 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    run_op(21, 7, 0, 1'b0);
    run_op(21, 3, 1, 1'b0);
    run_op(15, 4, 0, 1'b0);
    run_op(31, 1, 2, 1'b0);
    run_op(0, 5, 0, 1'b0);
    run_op(4, 7, 0, 1'b0);
    run_op(9, 0, 0, 1'b0);
    run_op(10, 3, 0, 1'b0);

    // Backpressure with input noise while busy
    run_op(27, 5, 10, 1'b1);

    // Asynchronous reset during the third CALC step of 20/6
    in_valid = 1'b1;
    dividend = DW'(20);
    divisor  = VW'(6);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_quotient", int'(quotient), 0);
    check("midrst_remainder", int'(remainder), 0);
    check("midrst_dbz", int'(dbz), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst_no_result", seen, 0);
    run_op(20, 6, 0, 1'b0);

    // Exhaustive sweep with random backpressure and input noise
    for (int a = 0; a < (1 << DW); a++) begin
      for (int b = 0; b < (1 << VW); b++) begin
        run_op(a, b, int'($urandom_range(0, 3)), 1'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_seq5x3.md
# div_seq5x3

Sequential restoring divider that inverts the small-operand multiplier path: it takes a dividend sized to hold a product and a divisor sized to one multiplier operand, and returns quotient and remainder. Operands are accepted over a valid/ready handshake. One quotient bit is produced per clock. The result is held on a valid/ready output handshake until consumed. The block sits beside the combinational multiplier in the arithmetic datapath and round-trips its results, e.g. a product divided by either operand.

## Interface
Parameters:
- DW, 5, dividend and quotient width
- VW, 3, divisor and remainder width; must satisfy 1 ≤ VW ≤ DW

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- dividend  input  DW  unsigned dividend
- divisor  input  VW  unsigned divisor
- out_valid  output  1  result present
- out_ready  input  1  consumer takes result
- quotient  output  DW  unsigned quotient
- remainder  output  VW  unsigned remainder
- dbz  output  1  divide-by-zero flag, qualified by out_valid

## Operation
- FSM states: IDLE, CALC, DONE.
- **IDLE**
  - in_ready=1.
  - When in_valid&in_ready, capture dividend and divisor.
  - Clear the partial remainder (VW+1 bits) and the step counter.
  - If divisor==0, go to DONE with quotient=all ones, remainder=0, dbz=1.
  - Otherwise go to CALC.
- **CALC**: one restoring step per cycle, consuming dividend bits MSB first.
  - Shift: pr = {pr[VW-1:0], next dividend bit}.
  - If pr ≥ divisor: pr -= divisor and the quotient bit = 1; else the quotient bit = 0.
  - After DW steps (counter reaches DW-1 and wraps), go to DONE.
  - remainder = pr[VW-1:0]. pr < divisor is guaranteed, so no truncation loss.
- **DONE**
  - out_valid=1. quotient, remainder and dbz are stable while out_valid is high.
  - When out_ready, go to IDLE.
- in_ready is 0 in CALC and DONE. in_valid in those states is ignored, not queued.
- Arithmetic is unsigned only. The compare uses VW+1 bits. No overflow is possible: the quotient always fits in DW.
- Reset, asynchronous at any time including mid-CALC or in DONE:
  - state=IDLE, in_ready=1, out_valid=0.
  - quotient=0, remainder=0, dbz=0, counter=0.
  - An operation in flight is discarded and produces no output.

## Timing
- Accept at edge E0.
  - Nonzero divisor: out_valid rises after edge E_DW, i.e. DW cycles after accept (5 with defaults).
  - Zero divisor: out_valid rises after E0+1 (1 cycle).
- Result is consumed at the first edge where out_valid&out_ready. in_ready is 1 in the following cycle.
- Minimum issue interval: DW+2 cycles (nonzero divisor, out_ready held high). No accept/result overlap.
- out_ready high before out_valid has no effect.
- Outputs are registered; there is no combinational path from inputs to outputs.
- quotient/remainder hold their last values in IDLE. Consumers must qualify with out_valid.

## Structure
- Package div_seq_pkg holds:
  - state enum (IDLE, CALC, DONE)
  - default width constants DW_DEF=5, VW_DEF=3
  - step-counter width constant $clog2(DW_DEF)
- Sub-module div_step: purely combinational single restoring iteration.
  - Inputs: pr, next dividend bit, divisor.
  - Outputs: next pr, quotient bit.
  - Instantiated once in the top level.
- The top level holds the FSM, counter, operand/quotient shift register and output registers.

## Test plan
- Product round-trip: dividend=21, divisor=7 → after 5 cycles out_valid=1, quotient=3, remainder=0, dbz=0. Also 21/3 → 7 r0.
- Nonzero remainder and extremes:
  - 15/4 → 3 r3
  - 31/1 → 31 r0
  - 0/5 → 0 r0
  - 4/7 → 0 r4
- Divide by zero: 9/0 → out_valid after 1 cycle, quotient=31, remainder=0, dbz=1. The next normal operation has dbz=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - Result stays stable and in_ready stays 0.
  - in_valid pulses during that window are ignored.
  - Releasing out_ready → in_ready=1 next cycle.
- Reset mid-operation: assert rst at CALC step 3 of 20/6.
  - All outputs go to reset values immediately; no result appears.
  - A following 20/6 → 3 r2.
- Exhaustive: all 32×8 operand pairs, checked against a reference model (q = a/b, r = a%b, dbz case as above).
  - Randomized out_ready backpressure.
  - Latency checked to be exactly 5 cycles (1 for divisor 0).
